// File: rtl/zjh_scan_capture.sv
// Receive side of a multiplexed seven-segment scan bus: waits for each scan slot
// to settle, decodes the segment pattern back to hex and holds one value per digit.
module zjh_scan_capture #(
    parameter int unsigned SETTLE         = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned WATCHDOG       = 1024
) (
    input  logic       Clock,
    input  logic       Aclr,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       Y3,
    input  logic       Y4,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dig_valid,
    output logic [3:0] blank,
    output logic       frame_done,
    output logic       seg_err,
    output logic       sel_err,
    output logic       stale
);

    localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
    localparam logic [15:0] WD_SAT    = 16'(WATCHDOG);
    localparam logic [15:0] WD_TRIP   = 16'(WATCHDOG - 1);

    logic [3:0]  in_sel;
    logic [6:0]  in_seg;
    logic [3:0]  s_sel;
    logic [6:0]  s_seg;
    logic        changed;
    logic [7:0]  cnt;
    logic        done;
    logic [15:0] wd;
    logic [3:0]  mask;
    logic [3:0]  dig_q [4];

    logic        fire;
    logic        one_hot;
    logic        multi;
    logic [1:0]  idx;
    logic [3:0]  idx_bit;
    logic [3:0]  seg_val;
    logic        seg_ok;
    logic        seg_blank;
    logic        cap_any;
    logic        cap_frame;
    logic        wd_trip;
    logic [3:0]  mask_next;

    // Selects are held active-high internally so the reset value means "no select".
    assign in_sel  = ~{Y4, Y3, Y2, Y1};
    assign in_seg  = SEG_ACTIVE_LOW ? ~{g, f, e, d, c, b, a} : {g, f, e, d, c, b, a};
    assign changed = ({in_sel, in_seg} != {s_sel, s_seg});

    assign digit0 = dig_q[0];
    assign digit1 = dig_q[1];
    assign digit2 = dig_q[2];
    assign digit3 = dig_q[3];

    always_comb begin
        seg_val   = '0;
        seg_ok    = 1'b0;
        seg_blank = 1'b0;
        case (s_seg)
            7'h3F: {seg_ok, seg_val} = 5'h10;
            7'h06: {seg_ok, seg_val} = 5'h11;
            7'h5B: {seg_ok, seg_val} = 5'h12;
            7'h4F: {seg_ok, seg_val} = 5'h13;
            7'h66: {seg_ok, seg_val} = 5'h14;
            7'h6D: {seg_ok, seg_val} = 5'h15;
            7'h7D: {seg_ok, seg_val} = 5'h16;
            7'h07: {seg_ok, seg_val} = 5'h17;
            7'h7F: {seg_ok, seg_val} = 5'h18;
            7'h6F: {seg_ok, seg_val} = 5'h19;
            7'h77: {seg_ok, seg_val} = 5'h1A;
            7'h7C: {seg_ok, seg_val} = 5'h1B;
            7'h39: {seg_ok, seg_val} = 5'h1C;
            7'h5E: {seg_ok, seg_val} = 5'h1D;
            7'h79: {seg_ok, seg_val} = 5'h1E;
            7'h71: {seg_ok, seg_val} = 5'h1F;
            7'h00: seg_blank = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        idx     = 2'd0;
        one_hot = 1'b1;
        case (s_sel)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
        idx_bit = 4'b0001 << idx;
        multi   = !one_hot && (s_sel != 4'b0000);
    end

    // One capture per dwell: 'done' blocks re-firing until S changes.
    assign fire      = (cnt == SETTLE_C) && !done;
    assign cap_any   = fire && one_hot;
    assign cap_frame = cap_any && (seg_ok || seg_blank);
    assign wd_trip   = !cap_any && (wd == WD_TRIP);

    always_comb begin
        mask_next = mask;
        if (mask == 4'hF || wd_trip) begin
            mask_next = '0;
        end
        if (cap_frame) begin
            mask_next = mask_next | idx_bit;
        end
    end

    always_ff @(posedge Clock or negedge Aclr) begin
        if (!Aclr) begin
            s_sel      <= '0;
            s_seg      <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            wd         <= '0;
            mask       <= '0;
            dig_q      <= '{default: '0};
            dig_valid  <= '0;
            blank      <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            sel_err    <= 1'b0;
            stale      <= 1'b0;
        end else begin
            s_sel <= in_sel;
            s_seg <= in_seg;

            if (changed) begin
                cnt  <= 8'd1;
                done <= 1'b0;
            end else begin
                if (cnt != SETTLE_C) begin
                    cnt <= cnt + 8'd1;
                end
                if (fire) begin
                    done <= 1'b1;
                end
            end

            sel_err    <= fire && multi;
            seg_err    <= cap_any && !seg_ok && !seg_blank;
            frame_done <= (mask == 4'hF);
            mask       <= mask_next;

            if (cap_any) begin
                wd <= '0;
            end else if (wd != WD_SAT) begin
                wd <= wd + 16'd1;
            end

            if (wd_trip) begin
                dig_valid <= '0;
                stale     <= 1'b1;
            end else if (cap_any) begin
                dig_valid[idx] <= seg_ok;
                if (seg_ok) begin
                    dig_q[idx] <= seg_val;
                    blank[idx] <= 1'b0;
                end
                if (seg_blank) begin
                    blank[idx] <= 1'b1;
                end
                if (cap_frame) begin
                    stale <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_zjh_scan_capture.sv
// Directed bench for zjh_scan_capture: a reference model pushes expected state into a
// queue at each dwell and the entry is popped and compared on the capture cycle.
module tb_zjh_scan_capture;

    localparam int unsigned SETTLE = 4;
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       Clock, Aclr;
    logic       Y1, Y2, Y3, Y4, a, b, c, d, e, f, g;
    logic [3:0] digit0, digit1, digit2, digit3, dig_valid, blank;
    logic       frame_done, seg_err, sel_err, stale;

    typedef struct {
        logic [15:0] digs;
        logic [3:0]  dv;
        logic [3:0]  bl;
        logic        seg_e;
        logic        sel_e;
        logic        st;
    } exp_t;

    exp_t        q [$];
    logic [3:0]  m_dig [4];
    logic [3:0]  m_dv, m_bl;
    logic        m_stale;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_cnt = 0;
    int          fd_wide = 0;
    logic        fd_prev = 1'b0;

    zjh_scan_capture #(.SETTLE(SETTLE), .SEG_ACTIVE_LOW(1'b1), .WATCHDOG(1024)) dut (
        .Clock(Clock), .Aclr(Aclr),
        .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .dig_valid(dig_valid), .blank(blank),
        .frame_done(frame_done), .seg_err(seg_err), .sel_err(sel_err), .stale(stale)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    always @(negedge Clock) begin
        if (frame_done) fd_cnt++;
        if (frame_done && fd_prev) fd_wide++;
        fd_prev = frame_done;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (SEG_TAB[i] == p) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_digs();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    endfunction

    function automatic logic [15:0] dut_digs();
        return {digit3, digit2, digit1, digit0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_dv    = '0;
        m_bl    = '0;
        m_stale = 1'b0;
    endtask

    // Drive one scan slot (sel_n = {Y4..Y1}, pat = active-high gfedcba) for n cycles.
    task automatic dwell(input logic [3:0] sel_n, input logic [6:0] pat, input int unsigned n);
        exp_t        ex;
        bit          cap;
        logic [3:0]  sel;
        logic [3:0]  old_dv;
        logic [15:0] old_digs;
        int          idx;
        int          v;
        cap = 1'b0;
        {Y4, Y3, Y2, Y1} = sel_n;
        {g, f, e, d, c, b, a} = ~pat;
        sel      = ~sel_n;
        old_dv   = m_dv;
        old_digs = model_digs();
        ex.seg_e = 1'b0;
        ex.sel_e = 1'b0;
        if (n >= SETTLE) begin
            if ($countones(sel) > 1) begin
                ex.sel_e = 1'b1;
            end else if ($countones(sel) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
                v = lookup(pat);
                if (pat == 7'h00) begin
                    m_bl[idx] = 1'b1;
                    m_dv[idx] = 1'b0;
                    m_stale   = 1'b0;
                end else if (v < 0) begin
                    ex.seg_e  = 1'b1;
                    m_dv[idx] = 1'b0;
                end else begin
                    m_dig[idx] = v[3:0];
                    m_dv[idx]  = 1'b1;
                    m_bl[idx]  = 1'b0;
                    m_stale    = 1'b0;
                end
            end
            ex.digs = model_digs();
            ex.dv   = m_dv;
            ex.bl   = m_bl;
            ex.st   = m_stale;
            q.push_back(ex);
            cap = 1'b1;
        end
        for (int unsigned j = 1; j <= n; j++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (cap && j == SETTLE) begin
                check("pre_capture_dv", 16'(dig_valid), 16'(old_dv));
                check("pre_capture_digits", dut_digs(), old_digs);
            end
            if (cap && j == SETTLE + 1) begin
                ex = q.pop_front();
                check("digits", dut_digs(), ex.digs);
                check("dig_valid", 16'(dig_valid), 16'(ex.dv));
                check("blank", 16'(blank), 16'(ex.bl));
                check("seg_err", 16'(seg_err), 16'(ex.seg_e));
                check("sel_err", 16'(sel_err), 16'(ex.sel_e));
                check("stale", 16'(stale), 16'(ex.st));
            end
            if (cap && j == SETTLE + 2) begin
                check("seg_err_width", 16'(seg_err), 16'h0);
                check("sel_err_width", 16'(sel_err), 16'h0);
            end
        end
        if (!cap) begin
            check("nocap_digits", dut_digs(), model_digs());
            check("nocap_dv", 16'(dig_valid), 16'(m_dv));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digits"}, dut_digs(), 16'h0);
        check({tag, "_valid_blank"}, {8'h0, dig_valid, blank}, 16'h0);
        check({tag, "_flags"}, 16'({frame_done, seg_err, sel_err, stale}), 16'h0);
    endtask

    initial begin
        model_reset();
        Aclr = 1'b0;
        {Y4, Y3, Y2, Y1} = 4'b1110;
        {g, f, e, d, c, b, a} = ~7'h4F;
        repeat (3) @(negedge Clock);
        check_all_zero("reset");

        // Idle bus, release reset, watchdog must trip on exactly the 1024th edge.
        {Y4, Y3, Y2, Y1} = 4'b1111;
        {g, f, e, d, c, b, a} = 7'h7F;
        Aclr = 1'b1;
        repeat (1023) @(posedge Clock);
        @(negedge Clock);
        check("stale_1023", 16'(stale), 16'h0);
        @(posedge Clock);
        @(negedge Clock);
        check("stale_1024", 16'(stale), 16'h1);
        m_stale = 1'b1;

        dwell(4'b1110, 7'h06, 8);
        dwell(4'b1110, 7'h07, 3);

        dwell(4'b1110, SEG_TAB[2], 8);
        dwell(4'b1101, SEG_TAB[10], 8);
        dwell(4'b1011, SEG_TAB[15], 8);
        dwell(4'b0111, SEG_TAB[8], 8);
        check("frame_count_1", 16'(fd_cnt), 16'd1);
        dwell(4'b1110, SEG_TAB[2], 8);
        dwell(4'b1101, SEG_TAB[10], 8);
        dwell(4'b1011, SEG_TAB[15], 8);
        dwell(4'b0111, SEG_TAB[8], 8);
        check("frame_count_2", 16'(fd_cnt), 16'd2);
        check("frame_width", 16'(fd_wide), 16'd0);

        dwell(4'b1101, 7'h00, 8);
        dwell(4'b1011, 7'h7E, 8);
        dwell(4'b1010, SEG_TAB[3], 8);
        dwell(4'b0111, SEG_TAB[3], 2);
        dwell(4'b0111, SEG_TAB[5], 8);

        // Last capture was on edge 5 of the 8-cycle dwell; 1021 more edges trip the watchdog.
        {Y4, Y3, Y2, Y1} = 4'b1111;
        {g, f, e, d, c, b, a} = 7'h7F;
        repeat (1020) @(posedge Clock);
        @(negedge Clock);
        check("idle_stale_pre", 16'(stale), 16'h0);
        check("idle_dv_pre", 16'(dig_valid), 16'(m_dv));
        @(posedge Clock);
        @(negedge Clock);
        check("idle_stale", 16'(stale), 16'h1);
        check("idle_dv_cleared", 16'(dig_valid), 16'h0);
        m_dv    = '0;
        m_stale = 1'b1;
        check("frame_count_final", 16'(fd_cnt), 16'd2);

        // Reset in the middle of a dwell, then the same inputs need a fresh full dwell.
        {Y4, Y3, Y2, Y1} = 4'b1110;
        {g, f, e, d, c, b, a} = ~SEG_TAB[9];
        repeat (2) @(posedge Clock);
        #2 Aclr = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge Clock);
        Aclr = 1'b1;
        dwell(4'b1110, SEG_TAB[9], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zjh_scan_capture.md
Name: zjh_scan_capture

Overview:
- Receive-side counterpart of the team's multiplexed seven-segment scan driver.
- Samples the active-low digit selects Y1..Y4 and the segment lines a..g, and waits for each scan slot to settle.
- Decodes each settled segment pattern back to a 4-bit hex value and holds one value per digit.
- Used for board-level loopback self-test and for monitoring a display bus driven by another scan driver.

Parameters:
- SETTLE, 4: consecutive identical samples required before a slot is captured (range 1..255).
- SEG_ACTIVE_LOW, 1: 1 = segment lit when line is 0; 0 = lit when line is 1.
- WATCHDOG, 1024: cycles without any capture before the stale flag is raised (range 2..65535).

Ports:
- Clock  input  1  system clock, rising edge.
- Aclr  input  1  asynchronous active-low reset.
- Y1, Y2, Y3, Y4  input  1 each  digit selects, active-low; Y1 is digit 0 and Y4 is digit 3.
- a, b, c, d, e, f, g  input  1 each  segment lines.
- digit0, digit1, digit2, digit3  output  4 each  last decoded hex value per digit.
- dig_valid  output  4  bit i = digit i holds a valid decoded value.
- blank  output  4  bit i = last capture of digit i was all segments dark.
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
- seg_err  output  1  one-cycle pulse when a capture sees an undecodable segment pattern.
- sel_err  output  1  one-cycle pulse when a settled sample has more than one select asserted.
- stale  output  1  level; no capture for WATCHDOG cycles.

Behaviour:
- Reset (Aclr=0, asynchronous): every register and output is 0 — digits, dig_valid, blank, pulse outputs, stale, the input register, the stability counter and the frame mask.
- Input stage: all 11 inputs are registered every cycle into a sample register S. The segment lines are normalised to active-high gfedcba according to SEG_ACTIVE_LOW. Inputs are treated as synchronous to Clock; no synchroniser is included.
- Stability counter:
  - Counts cycles for which S equals its previous value, saturating at SETTLE.
  - Resets to 1 on any change of S.
  - Once S has been loaded with the same value on edges k..k+SETTLE-1, the capture action happens on edge k+SETTLE.
  - Exactly one capture per dwell: no further capture until S changes.
- Select decode at capture:
  - None asserted (idle/blanking gap): no action.
  - Exactly one asserted: capture to index i.
  - More than one asserted: pulse sel_err; no digit update.
- Segment decode, gfedcba active-high to value:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - 00 = blank: set blank[i]=1, set dig_valid[i]=0, digit value held; counts as captured for frame purposes.
  - Any other pattern: pulse seg_err, clear dig_valid[i], leave blank[i] and the digit value unchanged; does not count as captured.
  - Valid pattern: update digit i, set dig_valid[i]=1, clear blank[i].
  - The decimal point is not monitored.
- Frame tracking:
  - A 4-bit mask records which digits have been captured.
  - When the mask becomes 1111, frame_done pulses on the following cycle and the mask clears on that same edge.
  - A capture arriving in that same cycle is recorded into the freshly cleared mask.
  - Recapturing an already-set digit before the frame completes only updates its value.
- Watchdog:
  - Counts cycles since the last capture of any kind, including blank and seg_err captures.
  - On reaching WATCHDOG it sets stale=1, clears dig_valid and clears the frame mask.
  - stale clears on the next valid or blank capture; the counter restarts at 0 on every capture.
- Simultaneous events: sel_err and seg_err never pulse in the same cycle, because a multi-select capture skips segment decode.

Test Plan:
- Reset: hold Aclr=0 with arbitrary inputs, then release -> all outputs 0; stale asserts after exactly 1024 cycles with no stimulus.
- Y1=0, other selects 1, segments = ~06 (active-low), held 4 cycles -> digit0=1, dig_valid=0001 on edge k+4. Holding a 3-cycle dwell with SETTLE=4 -> no update.
- Scan digit0..3 with patterns for 2,A,F,8 at 8 cycles each -> digit0..3 = 2,A,F,8, dig_valid=1111, frame_done single pulse after digit3's capture; a second scan yields a second pulse.
- Y2 with segments 0x00 (all dark) -> blank=0010, dig_valid[1]=0, digit1 unchanged; pattern 0x7E on Y3 -> seg_err pulse, dig_valid[2]=0, digit2 unchanged.
- Y1 and Y3 both low, stable -> sel_err one-cycle pulse, no digit change; a change of segments mid-dwell before SETTLE -> no capture.
- After stale is asserted, one valid capture -> stale=0 and dig_valid has only that digit's bit set. Asserting Aclr mid-dwell -> immediate clear and no capture on release until a fresh SETTLE dwell.
